// File: rtl/xup_piso_serializer_vector.sv
// xup_piso_serializer_vector
//
// Parallel-in, serial-out transmitter. A SIZE-bit word is taken on a
// load_valid/load_ready handshake. It is then shifted out one bit per clock
// edge on which en is high. A one-cycle done pulse follows the last bit.
//
// Parameters
//   SIZE      word width in bits (>= 1)
//   DELAY     clock-to-output delay (ns) of the original behavioural model;
//             this RTL is zero-delay, so the value has no effect here
//   MSB_FIRST 1: bit SIZE-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   d           parallel word, sampled only on an accepted load
//   load_valid  source requests a load of d
//   load_ready  block is idle and can accept a word (combinational)
//   en          bit-advance strobe, ignored while idle
//   sout        registered serial data bit
//   sout_valid  sout carries a word bit (high throughout SHIFT)
//   busy        high while a word is being shifted
//   done        one-cycle pulse after the last bit is consumed
module xup_piso_serializer_vector #(
  parameter int SIZE      = 4,
  parameter int DELAY     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] d,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            en,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [SIZE-1:0] sr, sr_d, sr_shift;
  logic [CW-1:0]   cnt, cnt_d;
  logic            sout_q, sout_d;
  logic            done_q, done_d;
  logic            load_bit, next_bit;

  // DELAY only shapes timing in the behavioural original.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  // The shift moves the register toward its output end, so the next bit
  // to send always sits at that end. Zeros fill the vacated position.
  always_comb begin
    sr_shift = MSB_FIRST ? (sr << 1) : (sr >> 1);
    next_bit = MSB_FIRST ? sr_shift[SIZE-1] : sr_shift[0];
    load_bit = MSB_FIRST ? d[SIZE-1] : d[0];
  end

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        sout_d = 1'b0;
        if (load_valid) begin
          state_d = SHIFT;
          sr_d    = d;
          cnt_d   = '0;
          sout_d  = load_bit;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt == LAST) begin
            state_d = IDLE;
            sout_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt + 1'b1;
            sr_d   = sr_shift;
            sout_d = next_bit;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      sr     <= sr_d;
      cnt    <= cnt_d;
      sout_q <= sout_d;
      done_q <= done_d;
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);
  assign sout       = sout_q;
  assign done       = done_q;

endmodule

// File: tb/tb_xup_piso_serializer_vector.sv
// Self-checking bench for xup_piso_serializer_vector: an MSB-first and an
// LSB-first 4-bit instance share one stimulus table; a 1-bit instance has
// its own hand-written sequence.
module tb_xup_piso_serializer_vector;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic       load_valid, en;
  logic [0:0] d1;
  logic       lv1, en1;

  logic rdy_m, sout_m, vld_m, busy_m, done_m;
  logic rdy_l, sout_l, vld_l, busy_l, done_l;
  logic rdy_1, sout_1, vld_1, busy_1, done_1;

  int checks   = 0;
  int failures = 0;
  int row      = 0;

  always #5 clk = ~clk;

  xup_piso_serializer_vector #(.SIZE(4), .DELAY(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .d(d), .load_valid(load_valid),
    .load_ready(rdy_m), .en(en), .sout(sout_m), .sout_valid(vld_m),
    .busy(busy_m), .done(done_m));

  xup_piso_serializer_vector #(.SIZE(4), .DELAY(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .d(d), .load_valid(load_valid),
    .load_ready(rdy_l), .en(en), .sout(sout_l), .sout_valid(vld_l),
    .busy(busy_l), .done(done_l));

  xup_piso_serializer_vector #(.SIZE(1), .DELAY(3), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .reset(reset), .d(d1), .load_valid(lv1),
    .load_ready(rdy_1), .en(en1), .sout(sout_1), .sout_valid(vld_1),
    .busy(busy_1), .done(done_1));

  // One row = inputs for one edge and the outputs expected just after it.
  typedef struct {
    logic       rst;
    logic       lv;
    logic [3:0] d;
    logic       en;
    logic       sm;   // expected sout, MSB-first instance
    logic       sl;   // expected sout, LSB-first instance
    logic       vld;  // expected sout_valid / busy (both instances)
    logic       dn;   // expected done (both instances)
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic lv, logic [3:0] dv, logic e,
                              logic sm, logic sl, logic vld, logic dn);
    vec_t v;
    v.rst = rst; v.lv = lv; v.d = dv; v.en = e;
    v.sm = sm; v.sl = sl; v.vld = vld; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b want=%b", name, row, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step1(logic r, logic lv, logic dv, logic e);
    @(negedge clk);
    reset = r; lv1 = lv; d1[0] = dv; en1 = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string name, logic s, logic v, logic dn);
    chk({name, "_sout"},  sout_1, s);
    chk({name, "_valid"}, vld_1,  v);
    chk({name, "_busy"},  busy_1, v);
    chk({name, "_ready"}, rdy_1,  ~v);
    chk({name, "_done"},  done_1, dn);
  endtask

  initial begin
    int n;
    reset = 1'b0; load_valid = 1'b0; en = 1'b0; d = '0;
    lv1 = 1'b0; en1 = 1'b0; d1 = '0;

    //   rst lv  d        en   sm   sl   vld  dn
    // reset state
    add(0, 0, 4'b0000, 0,   0,   0,   0,   0);
    // 1011 with en high; en on the load edge itself is ignored
    add(1, 1, 4'b1011, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   1);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   0);
    // 1001 with en every third edge
    add(1, 1, 4'b1001, 0,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 0,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 0,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 0,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 0,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 0,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 0,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 0,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 0,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   1);
    add(1, 0, 4'b0000, 0,   0,   0,   0,   0);
    // 1100 in flight while 0011 is offered every cycle
    add(1, 1, 4'b1100, 1,   1,   0,   1,   0);
    add(1, 1, 4'b0011, 1,   1,   0,   1,   0);
    add(1, 1, 4'b0011, 1,   0,   1,   1,   0);
    add(1, 1, 4'b0011, 1,   0,   1,   1,   0);
    add(1, 1, 4'b0011, 1,   0,   0,   0,   1);
    add(1, 1, 4'b0011, 1,   0,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   1);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   0);
    // reset on the edge carrying the 2nd en: word abandoned, no done
    add(1, 1, 4'b1011, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   1,   1,   0);
    add(0, 0, 4'b0000, 1,   0,   0,   0,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   0);
    // reset together with load_valid: nothing accepted
    add(0, 1, 4'b1111, 1,   0,   0,   0,   0);
    add(1, 0, 4'b1111, 1,   0,   0,   0,   0);
    add(1, 1, 4'b0110, 1,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   1,   1,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   1,   0);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   1);
    add(1, 0, 4'b0000, 1,   0,   0,   0,   0);

    foreach (vecs[i]) begin
      row = i;
      @(negedge clk);
      reset = vecs[i].rst; load_valid = vecs[i].lv;
      d = vecs[i].d; en = vecs[i].en;
      @(posedge clk);
      #1;
      chk("msb_sout",  sout_m, vecs[i].sm);
      chk("lsb_sout",  sout_l, vecs[i].sl);
      chk("msb_valid", vld_m,  vecs[i].vld);
      chk("lsb_valid", vld_l,  vecs[i].vld);
      chk("msb_busy",  busy_m, vecs[i].vld);
      chk("lsb_busy",  busy_l, vecs[i].vld);
      chk("msb_ready", rdy_m,  ~vecs[i].vld);
      chk("lsb_ready", rdy_l,  ~vecs[i].vld);
      chk("msb_done",  done_m, vecs[i].dn);
      chk("lsb_done",  done_l, vecs[i].dn);
    end

    // done latency with en held high, bounded wait
    row = -1;
    @(negedge clk);
    reset = 1'b1; load_valid = 1'b1; d = 4'b1010; en = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    @(negedge clk);
    load_valid = 1'b0;
    while (done_m !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_int("done_latency", n, 5);
    chk("latency_ready", rdy_m, 1'b1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done_m, 1'b0);

    // SIZE=1: first en edge in SHIFT completes the word
    row = 100;
    step1(1'b1, 1'b1, 1'b1, 1'b1); chk1("one_load",  1'b1, 1'b1, 1'b0);
    row = 101;
    step1(1'b1, 1'b0, 1'b0, 1'b1); chk1("one_done",  1'b0, 1'b0, 1'b1);
    row = 102;
    step1(1'b1, 1'b1, 1'b0, 1'b0); chk1("one_load0", 1'b0, 1'b1, 1'b0);
    row = 103;
    step1(1'b1, 1'b0, 1'b1, 1'b0); chk1("one_hold",  1'b0, 1'b1, 1'b0);
    row = 104;
    step1(1'b1, 1'b0, 1'b1, 1'b1); chk1("one_done2", 1'b0, 1'b0, 1'b1);
    row = 105;
    step1(1'b1, 1'b0, 1'b1, 1'b1); chk1("one_idle",  1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
